// File: rtl/drum_pkg.sv
`default_nettype none
// =============================================================================
// Module : drum_pkg
// Shared game state encoding, level codes and level-to-points mapping.
// Rev    : 1.0
// =============================================================================
package drum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam logic [1:0] LVL_EASY   = 2'd0;
  localparam logic [1:0] LVL_MEDIUM = 2'd1;
  localparam logic [1:0] LVL_HARD   = 2'd2;
  localparam logic [1:0] LVL_EXPERT = 2'd3;

  function automatic logic [1:0] points_for_level(input logic [1:0] level);
    case (level)
      LVL_EASY:   return 2'd1;
      LVL_MEDIUM: return 2'd2;
      default:    return 2'd3;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/drum_lane_track.sv
`default_nettype none
// =============================================================================
// Module : drum_lane_track
// One lane of falling notes: slot register, hit-window search, clear and shift.
// Rev    : 1.0
// =============================================================================
module drum_lane_track
  import drum_pkg::*;
#(
  parameter int SLOTS    = 16,
  parameter int HIT_SLOT = 13,
  parameter int WINDOW   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             active,
  input  logic             step,
  input  logic             spawn,
  input  logic             press,
  output logic             hit,
  output logic             exit_miss,
  output logic             bad_press,
  output logic [SLOTS-1:0] occupancy
);

  logic [SLOTS-1:0] slots_q, slots_d, judged;
  logic             found;
  int               sel;

  always_comb begin
    judged    = slots_q;
    slots_d   = slots_q;
    hit       = 1'b0;
    exit_miss = 1'b0;
    bad_press = 1'b0;
    found     = 1'b0;
    sel       = 0;
    // Ascending scan so the highest occupied slot in the window wins
    for (int s = HIT_SLOT - WINDOW; s <= HIT_SLOT + WINDOW; s++) begin
      if (slots_q[s]) begin
        found = 1'b1;
        sel   = s;
      end
    end
    if (clear) begin
      slots_d = '0;
    end else if (active) begin
      if (press) begin
        if (found) begin
          judged[sel] = 1'b0;
          hit         = 1'b1;
        end else begin
          bad_press = 1'b1;
        end
      end
      if (step) begin
        exit_miss = judged[SLOTS-1];
        slots_d   = {judged[SLOTS-2:0], spawn};
      end else begin
        slots_d = judged;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) slots_q <= '0;
    else        slots_q <= slots_d;
  end

  assign occupancy = slots_q;

endmodule
`default_nettype wire

// File: rtl/drum_lane_scorer.sv
`default_nettype none
// =============================================================================
// Module : drum_lane_scorer
// Drum game note-lane engine: pad timing, hit judging, score/combo/miss keeping.
// Rev    : 1.0
// =============================================================================
module drum_lane_scorer
  import drum_pkg::*;
#(
  parameter int LANES      = 5,
  parameter int SLOTS      = 16,
  parameter int HIT_SLOT   = 13,
  parameter int WINDOW     = 1,
  parameter int SCORE_W    = 13,
  parameter int COMBO_W    = 5,
  parameter int MAX_MISSES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   step,
  input  logic [1:0]             level,
  input  logic [LANES-1:0]       spawn,
  input  logic [LANES-1:0]       pads,
  output logic [LANES*SLOTS-1:0] lane_notes,
  output logic [SCORE_W-1:0]     score,
  output logic [COMBO_W-1:0]     combo,
  output logic [3:0]             misses,
  output logic [LANES-1:0]       hit_pulse,
  output logic                   playing,
  output logic                   game_over
);

  localparam int                 GAIN_W    = SCORE_W + 5;
  localparam logic [GAIN_W-1:0]  SCORE_MAX = {5'd0, {SCORE_W{1'b1}}};
  localparam int                 COMBO_MAX = (1 << COMBO_W) - 1;

  logic [LANES-1:0]   sync1_q, sync2_q, sync3_q, press_q;
  logic [LANES-1:0]   hit_vec, exit_vec, bad_vec;
  logic [LANES-1:0]   hit_pulse_q, hit_pulse_d;
  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [3:0]         misses_q, misses_d;
  logic               live, lanes_active;
  logic [GAIN_W-1:0]  gain, score_sum;
  int                 n_hit, n_exit, n_bad, mult, combo_sum, miss_sum;

  // The cycle in which misses hits the limit is a dead cycle before OVER
  assign live         = (state_q == PLAY) && (int'(misses_q) < MAX_MISSES);
  assign lanes_active = live && !start;

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      drum_lane_track #(
        .SLOTS    (SLOTS),
        .HIT_SLOT (HIT_SLOT),
        .WINDOW   (WINDOW)
      ) u_track (
        .clk       (clk),
        .reset     (reset),
        .clear     (start),
        .active    (lanes_active),
        .step      (step),
        .spawn     (spawn[l]),
        .press     (press_q[l]),
        .hit       (hit_vec[l]),
        .exit_miss (exit_vec[l]),
        .bad_press (bad_vec[l]),
        .occupancy (lane_notes[l*SLOTS +: SLOTS])
      );
    end
  endgenerate

  always_comb begin
    n_hit  = 0;
    n_exit = 0;
    n_bad  = 0;
    for (int l = 0; l < LANES; l++) begin
      n_hit  += int'(hit_vec[l]);
      n_exit += int'(exit_vec[l]);
      n_bad  += int'(bad_vec[l]);
    end
    mult = int'(combo_q >> 2);
    if (mult > 3) mult = 3;
    mult      = mult + 1;
    gain      = GAIN_W'(n_hit) * GAIN_W'(points_for_level(level)) * GAIN_W'(mult);
    score_sum = {5'd0, score_q} + gain;
    combo_sum = int'(combo_q) + n_hit;
    miss_sum  = int'(misses_q) + n_exit;

    state_d     = state_q;
    score_d     = score_q;
    combo_d     = combo_q;
    misses_d    = misses_q;
    hit_pulse_d = '0;

    if (start) begin
      state_d  = PLAY;
      score_d  = '0;
      combo_d  = '0;
      misses_d = '0;
    end else if (state_q == PLAY) begin
      if (!live) begin
        state_d = OVER;
      end else begin
        hit_pulse_d = hit_vec;
        score_d     = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
        if (n_exit + n_bad > 0)       combo_d = '0;
        else if (combo_sum > COMBO_MAX) combo_d = COMBO_W'(COMBO_MAX);
        else                          combo_d = COMBO_W'(combo_sum);
        misses_d = (miss_sum > MAX_MISSES) ? 4'(MAX_MISSES) : 4'(miss_sum);
      end
    end
  end

  // Three pad stages plus a registered edge put the judgement three edges after the rise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      press_q     <= '0;
      state_q     <= IDLE;
      score_q     <= '0;
      combo_q     <= '0;
      misses_q    <= '0;
      hit_pulse_q <= '0;
    end else begin
      sync1_q     <= pads;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      press_q     <= sync2_q & ~sync3_q;
      state_q     <= state_d;
      score_q     <= score_d;
      combo_q     <= combo_d;
      misses_q    <= misses_d;
      hit_pulse_q <= hit_pulse_d;
    end
  end

  assign score     = score_q;
  assign combo     = combo_q;
  assign misses    = misses_q;
  assign hit_pulse = hit_pulse_q;
  assign playing   = (state_q == PLAY);
  assign game_over = (state_q == OVER);

endmodule
`default_nettype wire

// File: tb/tb_drum_lane_scorer.sv
`default_nettype none
// =============================================================================
// Module : tb_drum_lane_scorer
// Self-checking bench: directed table, hand-written corner sequences, random play.
// Rev    : 1.0
// =============================================================================
module tb_drum_lane_scorer;

  localparam int LANES = 5, SLOTS = 16, HIT_SLOT = 13, WINDOW = 1;
  localparam int SCORE_W = 13, COMBO_W = 5, MAX_MISSES = 8;
  localparam int NB = LANES * SLOTS;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             step = 1'b0;
  logic [1:0]       level = 2'd0;
  logic [LANES-1:0] spawn = '0;
  logic [LANES-1:0] pads = '0;
  logic [NB-1:0]    lane_notes;
  logic [SCORE_W-1:0] score;
  logic [COMBO_W-1:0] combo;
  logic [3:0]       misses;
  logic [LANES-1:0] hit_pulse;
  logic             playing, game_over;

  drum_lane_scorer dut (
    .clk(clk), .reset(reset), .start(start), .step(step), .level(level),
    .spawn(spawn), .pads(pads), .lane_notes(lane_notes), .score(score),
    .combo(combo), .misses(misses), .hit_pulse(hit_pulse),
    .playing(playing), .game_over(game_over)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad = 0;

  // ---------------- reference model ----------------
  int               m_state;  // 0 idle, 1 play, 2 over
  bit               m_lane[LANES][SLOTS];
  int               m_score, m_combo, m_misses;
  logic [LANES-1:0] m_hitp;
  logic [LANES-1:0] ph[4];    // pad levels of the last four cycles, newest first

  task automatic m_reset();
    m_state = 0; m_score = 0; m_combo = 0; m_misses = 0; m_hitp = '0;
    for (int l = 0; l < LANES; l++) for (int s = 0; s < SLOTS; s++) m_lane[l][s] = 1'b0;
    for (int i = 0; i < 4; i++) ph[i] = '0;
  endtask

  task automatic m_edge(input bit st, input bit stp, input logic [LANES-1:0] spn,
                        input logic [LANES-1:0] pd, input logic [1:0] lvl);
    logic [LANES-1:0] press;
    int h, bp, ex, found, pts, mult;
    press = ph[2] & ~ph[3];
    ph[3] = ph[2]; ph[2] = ph[1]; ph[1] = ph[0]; ph[0] = pd;
    m_hitp = '0;
    if (st) begin
      m_state = 1; m_score = 0; m_combo = 0; m_misses = 0;
      for (int l = 0; l < LANES; l++) for (int s = 0; s < SLOTS; s++) m_lane[l][s] = 1'b0;
    end else if (m_state == 1 && m_misses >= MAX_MISSES) begin
      m_state = 2;
    end else if (m_state == 1) begin
      h = 0; bp = 0; ex = 0;
      for (int l = 0; l < LANES; l++) begin
        if (press[l]) begin
          found = -1;
          for (int s = HIT_SLOT - WINDOW; s <= HIT_SLOT + WINDOW; s++) if (m_lane[l][s]) found = s;
          if (found >= 0) begin
            m_lane[l][found] = 1'b0; h++; m_hitp[l] = 1'b1;
          end else bp++;
        end
      end
      if (stp) begin
        for (int l = 0; l < LANES; l++) begin
          if (m_lane[l][SLOTS-1]) ex++;
          for (int s = SLOTS - 1; s > 0; s--) m_lane[l][s] = m_lane[l][s-1];
          m_lane[l][0] = spn[l];
        end
      end
      pts  = (lvl == 0) ? 1 : (lvl == 1) ? 2 : 3;
      mult = 1 + (((m_combo / 4) > 3) ? 3 : (m_combo / 4));
      m_score = m_score + h * pts * mult;
      if (m_score > (1 << SCORE_W) - 1) m_score = (1 << SCORE_W) - 1;
      if (ex + bp > 0) m_combo = 0;
      else m_combo = (m_combo + h > (1 << COMBO_W) - 1) ? (1 << COMBO_W) - 1 : m_combo + h;
      m_misses = (m_misses + ex > MAX_MISSES) ? MAX_MISSES : m_misses + ex;
    end
  endtask

  function automatic logic [NB-1:0] m_notes();
    logic [NB-1:0] v;
    v = '0;
    for (int l = 0; l < LANES; l++) for (int s = 0; s < SLOTS; s++) v[l*SLOTS+s] = m_lane[l][s];
    return v;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("m.notes", 128'(lane_notes), 128'(m_notes()));
    check("m.score", 128'(score), 128'(m_score));
    check("m.combo", 128'(combo), 128'(m_combo));
    check("m.misses", 128'(misses), 128'(m_misses));
    check("m.hit_pulse", 128'(hit_pulse), 128'(m_hitp));
    check("m.playing", 128'(playing), 128'(m_state == 1));
    check("m.game_over", 128'(game_over), 128'(m_state == 2));
  endtask

  logic [1:0] cur_lvl = 2'd0;

  task automatic tick(input bit st, input bit stp, input logic [LANES-1:0] spn,
                      input logic [LANES-1:0] pd);
    start = st; step = stp; spawn = spn; pads = pd; level = cur_lvl;
    @(posedge clk);
    m_edge(st, stp, spn, pd, cur_lvl);
    @(negedge clk);
    check_model();
  endtask

  // One pad rise followed by three low cycles; the judgement lands on the last tick
  task automatic press(input logic [LANES-1:0] ln, input bit step_last);
    tick(0, 0, '0, ln);
    tick(0, 0, '0, '0);
    tick(0, 0, '0, '0);
    tick(0, step_last, '0, '0);
  endtask

  function automatic logic [NB-1:0] nb(input int lane, input int first, input int count);
    logic [NB-1:0] v;
    v = '0;
    for (int i = 0; i < count; i++) v[lane*SLOTS + first + i] = 1'b1;
    return v;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    bit               st;
    bit               stp;
    logic [LANES-1:0] spn;
    logic [LANES-1:0] pd;
    logic [1:0]       lvl;
    int               reps;
    bit               cn;
    logic [NB-1:0]    notes;
    int               sc;
    int               cb;
    logic [LANES-1:0] hp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit st, input bit stp, input logic [LANES-1:0] spn,
                     input logic [LANES-1:0] pd, input logic [1:0] lvl, input int reps,
                     input bit cn, input logic [NB-1:0] notes, input int sc, input int cb,
                     input logic [LANES-1:0] hp);
    vec_t v;
    v.st = st; v.stp = stp; v.spn = spn; v.pd = pd; v.lvl = lvl; v.reps = reps;
    v.cn = cn; v.notes = notes; v.sc = sc; v.cb = cb; v.hp = hp;
    tbl.push_back(v);
  endtask

  initial begin
    int scs[5];
    logic [NB-1:0] saved;
    scs = '{2, 4, 6, 8, 12};
    m_reset();

    @(negedge clk);
    check("rst.score", 128'(score), 0);
    check("rst.combo", 128'(combo), 0);
    check("rst.misses", 128'(misses), 0);
    check("rst.notes", 128'(lane_notes), 0);
    check("rst.playing", 128'(playing), 0);
    check("rst.game_over", 128'(game_over), 0);
    check("rst.hit_pulse", 128'(hit_pulse), 0);
    reset = 1'b1;

    // Lane 0 single hit, then five consecutive lane 2 hits at level 1
    add(1, 0, 5'b00000, 5'b00000, 0, 1, 1, nb(0, 0, 0), 0, 0, 5'b00000);
    add(0, 1, 5'b00001, 5'b00000, 0, 1, 1, nb(0, 0, 1), 0, 0, 5'b00000);
    add(0, 1, 5'b00000, 5'b00000, 0, 13, 1, nb(0, 13, 1), 0, 0, 5'b00000);
    add(0, 0, 5'b00000, 5'b00001, 0, 1, 1, nb(0, 13, 1), 0, 0, 5'b00000);
    add(0, 0, 5'b00000, 5'b00001, 0, 2, 1, nb(0, 13, 1), 0, 0, 5'b00000);
    add(0, 0, 5'b00000, 5'b00000, 0, 1, 1, nb(0, 0, 0), 1, 1, 5'b00001);
    add(0, 0, 5'b00000, 5'b00000, 0, 1, 1, nb(0, 0, 0), 1, 1, 5'b00000);
    add(1, 0, 5'b00000, 5'b00000, 1, 1, 1, nb(0, 0, 0), 0, 0, 5'b00000);
    add(0, 1, 5'b00100, 5'b00000, 1, 5, 1, nb(2, 0, 5), 0, 0, 5'b00000);
    add(0, 1, 5'b00000, 5'b00000, 1, 9, 1, nb(2, 9, 5), 0, 0, 5'b00000);
    for (int i = 1; i <= 5; i++) begin
      add(0, 0, 5'b00000, 5'b00100, 1, 1, 0, '0, (i == 1) ? 0 : scs[i-2], i - 1, 5'b00000);
      add(0, 0, 5'b00000, 5'b00000, 1, 3, 1, nb(2, 8 + i, 5 - i), scs[i-1], i, 5'b00100);
      add(0, 1, 5'b00000, 5'b00000, 1, 1, 0, '0, scs[i-1], i, 5'b00000);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      cur_lvl = tbl[i].lvl;
      for (int r = 0; r < tbl[i].reps; r++) tick(tbl[i].st, tbl[i].stp, tbl[i].spn, tbl[i].pd);
      check($sformatf("tbl%0d.score", i), 128'(score), 128'(tbl[i].sc));
      check($sformatf("tbl%0d.combo", i), 128'(combo), 128'(tbl[i].cb));
      check($sformatf("tbl%0d.hit_pulse", i), 128'(hit_pulse), 128'(tbl[i].hp));
      check($sformatf("tbl%0d.misses", i), 128'(misses), 0);
      check($sformatf("tbl%0d.playing", i), 128'(playing), 1);
      if (tbl[i].cn) check($sformatf("tbl%0d.notes", i), 128'(lane_notes), 128'(tbl[i].notes));
    end

    // Eight notes fall out: game over, inputs ignored, restart clears
    cur_lvl = 0;
    tick(1, 0, '0, '0);
    tick(0, 1, 5'b11111, '0);
    tick(0, 1, 5'b00111, '0);
    repeat (15) tick(0, 1, '0, '0);
    check("over.misses5", 128'(misses), 5);
    tick(0, 1, '0, '0);
    check("over.misses8", 128'(misses), 8);
    check("over.still_playing", 128'(game_over), 0);
    tick(0, 0, '0, '0);
    check("over.game_over", 128'(game_over), 1);
    check("over.playing", 128'(playing), 0);
    saved = lane_notes;
    for (int i = 0; i < 6; i++) tick(0, 1, 5'b11111, (i % 2 == 0) ? 5'b11111 : 5'b00000);
    check("over.notes_hold", 128'(lane_notes), 128'(saved));
    check("over.misses_hold", 128'(misses), 8);
    check("over.score_hold", 128'(score), 0);
    repeat (4) tick(0, 0, '0, '0);
    tick(1, 0, '0, '0);
    check("restart.playing", 128'(playing), 1);
    check("restart.misses", 128'(misses), 0);
    check("restart.notes", 128'(lane_notes), 0);
    check("restart.game_over", 128'(game_over), 0);

    // Bad press at combo 3
    tick(1, 0, '0, '0);
    repeat (3) tick(0, 1, 5'b00001, '0);
    repeat (12) tick(0, 1, '0, '0);
    press(5'b00001, 0);
    press(5'b00001, 0);
    press(5'b00001, 0);
    check("badp.combo3", 128'(combo), 3);
    check("badp.score3", 128'(score), 3);
    press(5'b00001, 0);
    check("badp.combo", 128'(combo), 0);
    check("badp.score", 128'(score), 3);
    check("badp.misses", 128'(misses), 0);
    check("badp.hit_pulse", 128'(hit_pulse), 0);

    // Hit on lane 0 in the same cycle as an exit miss on lane 1, combo 6
    tick(1, 0, '0, '0);
    tick(0, 1, 5'b00010, '0);
    tick(0, 1, 5'b01101, '0);
    tick(0, 1, 5'b01101, '0);
    tick(0, 1, 5'b00001, '0);
    repeat (12) tick(0, 1, '0, '0);
    press(5'b01101, 0);
    press(5'b01101, 0);
    check("same.combo6", 128'(combo), 6);
    check("same.score6", 128'(score), 6);
    press(5'b00001, 1);
    check("same.score", 128'(score), 8);
    check("same.combo", 128'(combo), 0);
    check("same.misses", 128'(misses), 1);
    check("same.hit_pulse", 128'(hit_pulse), 5'b00001);
    check("same.notes", 128'(lane_notes), 0);

    // Score saturation at level 3
    cur_lvl = 3;
    tick(1, 0, '0, '0);
    repeat (200) begin
      tick(0, 1, 5'b11111, '0);
      tick(0, 0, '0, 5'b11111);
    end
    check("sat.score", 128'(score), 8191);
    check("sat.combo", 128'(combo), 31);
    check("sat.misses", 128'(misses), 0);

    // Asynchronous reset in the middle of a cycle
    #3 reset = 1'b0;
    #1;
    check("arst.score", 128'(score), 0);
    check("arst.combo", 128'(combo), 0);
    check("arst.notes", 128'(lane_notes), 0);
    check("arst.playing", 128'(playing), 0);
    check("arst.hit_pulse", 128'(hit_pulse), 0);
    check("arst.misses", 128'(misses), 0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;

    // Random play against the model
    tick(1, 0, '0, '0);
    repeat (1500) begin
      cur_lvl = 2'($urandom_range(0, 3));
      tick($urandom_range(0, 79) == 0, 1'($urandom_range(0, 1)),
           LANES'($urandom & $urandom & $urandom), LANES'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
